serial_word_tx: RTL and testbench



---
 rtl/serial_word_pkg.sv | 30 +++
 rtl/serial_word_tx_bit_timer.sv | 33 +++
 rtl/serial_word_tx.sv | 170 +++++++++++++++++
 tb/tb_serial_word_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_pkg.sv
// Shared definitions for the serial word link (transmitter and receiver).
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents: frame state enum, default widths, line levels, frame_bits().
package serial_word_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_TAG    = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_TAG_W        = 2;
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_PARITY_EN    = 1;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Number of serial bits in one frame: start + tag + data + parity + stop.
  function automatic int frame_bits(input int tag_w, input int data_w, input int parity_en);
    return 1 + tag_w + data_w + parity_en + 1;
  endfunction

endpackage

// File: rtl/serial_word_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, tick on the last count.
// Latency: tick is combinational from the counter register.
// Backpressure: none; clear holds the count at 0.
//
// Ports: clk, rst (sync, active-high), clear (hold at 0), tick (last cycle of a bit).
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // With CLKS_PER_BIT=1 the count never leaves 0, so tick is high every cycle.
  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/serial_word_tx.sv
// Bit-serial transmitter: frames {start, tag, data, parity, stop} onto tx_bit, MSB first.
// Latency: tx_bit drops to the start level the cycle after the transfer edge.
// Backpressure: in_ready only in IDLE; in_valid while busy is ignored, not queued.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_tag accept one pair;
//        tx_bit serial line (idles 1), tx_busy frame in progress, tx_done pulse after stop.
module serial_word_tx
  import serial_word_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int TAG_W        = DEF_TAG_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = DEF_PARITY_EN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              tx_bit,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int TOT_W = TAG_W + DATA_W;
  localparam int MAX_W = (DATA_W > TAG_W) ? DATA_W : TAG_W;
  localparam int IW    = $clog2(MAX_W) + 1;

  localparam logic [IW-1:0] TAG_LAST  = IW'(TAG_W - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);

  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic [TOT_W-1:0] r_word;
  logic [TOT_W-1:0] w_word_nxt;
  logic             r_par;
  logic             r_tx_bit;
  logic             r_busy;
  logic             r_done;
  logic             w_line_nxt;
  logic             w_done_nxt;
  logic             w_xfer;
  logic             w_tick;

  assign in_ready = (r_state == ST_IDLE) && !rst;
  assign w_xfer   = in_valid && in_ready;

  // Timer is held at 0 throughout IDLE, so the start bit gets a full period
  // beginning the cycle after the transfer edge.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(r_state == ST_IDLE),
    .tick (w_tick)
  );

  // Next state, bit index and shift register.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;

    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_state_nxt = ST_START;
          w_idx_nxt   = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_TAG;
          w_idx_nxt   = '0;
        end
      end
      ST_TAG: begin
        if (w_tick) begin
          if (r_idx == TAG_LAST) begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_idx == DATA_LAST) begin
            w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    // The MSB of the shift register is always the tag/data bit on the line;
    // shifting at the end of each tag/data bit presents the next one.
    if (w_xfer) begin
      w_word_nxt = {in_tag, in_data};
    end else if (w_tick && (r_state == ST_TAG || r_state == ST_DATA)) begin
      w_word_nxt = {r_word[TOT_W-2:0], 1'b0};
    end
  end

  // Line level for the next cycle, registered so tx_bit has no input path.
  always_comb begin
    w_line_nxt = IDLE_LEVEL;
    case (w_state_nxt)
      ST_IDLE:   w_line_nxt = IDLE_LEVEL;
      ST_START:  w_line_nxt = START_LEVEL;
      ST_TAG:    w_line_nxt = w_word_nxt[TOT_W-1];
      ST_DATA:   w_line_nxt = w_word_nxt[TOT_W-1];
      ST_PARITY: w_line_nxt = r_par;
      ST_STOP:   w_line_nxt = 1'b1;
      default:   w_line_nxt = IDLE_LEVEL;
    endcase
  end

  assign w_done_nxt = (r_state == ST_STOP) && w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_tx_bit <= IDLE_LEVEL;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_tx_bit <= w_line_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= w_done_nxt;
    end
  end

  // Payload and its even parity; only meaningful while a frame is running.
  always_ff @(posedge clk) begin
    r_word <= w_word_nxt;
    if (w_xfer) begin
      r_par <= ^{in_tag, in_data};
    end
  end

  assign tx_bit  = r_tx_bit;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: three instances cover the default
// configuration, PARITY_EN=0, and CLKS_PER_BIT=1. Expected frames come from a
// bit-list model built straight from the frame format.
module tb_serial_word_tx;
  import serial_word_pkg::*;

  localparam int N = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        vld;
  logic [N-1:0][15:0]  dat;
  logic [N-1:0][1:0]   tg;
  wire  [N-1:0]        rdy;
  wire  [N-1:0]        txb;
  wire  [N-1:0]        busy;
  wire  [N-1:0]        done;

  int checks   = 0;
  int failures = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  serial_word_tx #(.DATA_W(16), .TAG_W(2), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]),
    .in_tag(tg[0]), .tx_bit(txb[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  serial_word_tx #(.DATA_W(16), .TAG_W(2), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1]),
    .in_tag(tg[1]), .tx_bit(txb[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  serial_word_tx #(.DATA_W(16), .TAG_W(2), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(dat[2]),
    .in_tag(tg[2]), .tx_bit(txb[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  function automatic int cpb_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int par_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference frame as a list of serial bits.
  function automatic void build_frame(input logic [15:0] d, input logic [1:0] t, input int par);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 1; i >= 0; i--) exp_q.push_back(t[i]);
    for (int i = 15; i >= 0; i--) exp_q.push_back(d[i]);
    if (par != 0) begin
      ones = $countones(d) + $countones(t);
      exp_q.push_back((ones % 2) == 1);
    end
    exp_q.push_back(1'b1);
  endfunction

  task automatic start_xfer(input int k, input logic [15:0] d, input logic [1:0] t);
    int n = 0;
    @(negedge clk);
    while (!rdy[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rdy_wait_bound", 32'(n < 200), 32'd1);
    vld[k] = 1'b1;
    dat[k] = d;
    tg[k]  = t;
    @(posedge clk);
  endtask

  // Called after the transfer edge; checks every cycle of the frame and the done cycle.
  // With hold set, in_valid stays high and the inputs switch to the next pair
  // mid-frame, so the next transfer happens in the done cycle.
  task automatic check_frame(input int k, input logic [15:0] d, input logic [1:0] t,
                             input bit hold, input logic [15:0] nd, input logic [1:0] nt,
                             output int nbusy, output logic [20:0] cap);
    int cpb;
    int len;
    cpb = cpb_of(k);
    build_frame(d, t, par_of(k));
    len   = exp_q.size() * cpb;
    nbusy = 0;
    cap   = '0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (hold) begin
          dat[k] = nd;
          tg[k]  = nt;
        end else begin
          vld[k] = 1'b0;
        end
      end
      check("line", 32'(txb[k]), 32'(exp_q[i / cpb]));
      check("busy_in_frame", 32'(busy[k]), 32'd1);
      check("done_early", 32'(done[k]), 32'd0);
      check("rdy_in_frame", 32'(rdy[k]), 32'd0);
      if (busy[k]) nbusy++;
      if ((i % cpb) == cpb - 1) cap = {cap[19:0], txb[k]};
    end
    @(negedge clk);
    check("done_pulse", 32'(done[k]), 32'd1);
    check("busy_after", 32'(busy[k]), 32'd0);
    check("idle_line", 32'(txb[k]), 32'd1);
    check("rdy_after", 32'(rdy[k]), 32'd1);
    check("frame_len", 32'(nbusy), 32'(frame_bits(2, 16, par_of(k)) * cpb));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nb;
    logic [20:0] cap;
    logic [15:0] d1, d2;
    logic [1:0]  t1, t2;

    rst = 1'b1;
    vld = '0;
    dat = '0;
    tg  = '0;

    // Reset from power-up.
    repeat (3) begin
      @(negedge clk);
      check("rst_rdy", 32'(rdy), 32'd0);
      check("rst_line", 32'(txb), 32'h7);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 32'(rdy), 32'h7);
    check("post_rst_line", 32'(txb), 32'h7);

    // Reset held 3 cycles mid-idle.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_rst_rdy", 32'(rdy), 32'd0);
      check("idle_rst_line", 32'(txb), 32'h7);
      check("idle_rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("idle_rst_rdy_after", 32'(rdy), 32'h7);

    // Directed frames, default configuration.
    start_xfer(0, 16'h4565, 2'b01);
    check_frame(0, 16'h4565, 2'b01, 1'b0, 16'h0, 2'b0, nb, cap);
    check("frame_4565", 32'(cap), 32'({1'b0, 2'b01, 16'h4565, 1'b0, 1'b1}));
    check("len_84", 32'(nb), 32'd84);

    start_xfer(0, 16'h4564, 2'b01);
    check_frame(0, 16'h4564, 2'b01, 1'b0, 16'h0, 2'b0, nb, cap);
    check("parity_4564", 32'(cap[1]), 32'd1);

    start_xfer(0, 16'h3267, 2'b10);
    check_frame(0, 16'h3267, 2'b10, 1'b0, 16'h0, 2'b0, nb, cap);
    check("parity_3267", 32'(cap[1]), 32'd1);

    // No parity: 20 bits, 80 cycles.
    start_xfer(1, 16'h4565, 2'b01);
    check_frame(1, 16'h4565, 2'b01, 1'b0, 16'h0, 2'b0, nb, cap);
    check("frame_nopar", 32'(cap[19:0]), 32'({1'b0, 2'b01, 16'h4565, 1'b1}));
    check("len_80", 32'(nb), 32'd80);

    // One clock per bit.
    start_xfer(2, 16'hFFFF, 2'b11);
    check_frame(2, 16'hFFFF, 2'b11, 1'b0, 16'h0, 2'b0, nb, cap);
    check("frame_ffff", 32'(cap), 32'({1'b0, 2'b11, 16'hFFFF, 1'b0, 1'b1}));
    check("len_21", 32'(nb), 32'd21);

    // Back-to-back with in_valid held and inputs changed mid-frame.
    for (int k = 0; k < N; k++) begin
      d1 = 16'($urandom);
      t1 = 2'($urandom);
      d2 = 16'($urandom);
      t2 = 2'($urandom);
      start_xfer(k, d1, t1);
      check_frame(k, d1, t1, 1'b1, d2, t2, nb, cap);
      check_frame(k, d2, t2, 1'b0, 16'h0, 2'b0, nb, cap);
    end

    // Abort during data bit 7 (frame bit 10, cycles 40..43).
    start_xfer(0, 16'hA5C3, 2'b10);
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      if (i == 0) vld[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_line", 32'(txb[0]), 32'd1);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_done", 32'(done[0]), 32'd0);
    check("abort_rdy_in_rst", 32'(rdy[0]), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done[0]), 32'd0);
      check("abort_idle_line", 32'(txb[0]), 32'd1);
      check("abort_rdy", 32'(rdy[0]), 32'd1);
    end
    start_xfer(0, 16'h1234, 2'b01);
    check_frame(0, 16'h1234, 2'b01, 1'b0, 16'h0, 2'b0, nb, cap);

    // Randomised frames on every configuration.
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 4; j++) begin
        d1 = 16'($urandom);
        t1 = 2'($urandom_range(3, 0));
        start_xfer(k, d1, t1);
        check_frame(k, d1, t1, 1'b0, 16'h0, 2'b0, nb, cap);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
